// File: rtl/dbg_slave_pkg.sv
// Shared constants, helpers and the command record for the system-clock half
// of the JTAG debug slave.
package dbg_slave_pkg;

    localparam int DEF_IR_WIDTH   = 2;
    localparam int DEF_DR_WIDTH   = 38;
    localparam int DEF_ACTION_BIT = 34;

    // Ceiling log2 usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic [DEF_IR_WIDTH-1:0] ir;
        logic [DEF_DR_WIDTH-1:0] data;
    } dbg_cmd_t;

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-stage synchroniser followed by a rising-edge detector. All flops reset
// high so a level that is already asserted at reset release is not an event.
module dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            delayed_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~delayed_q;

endmodule

// File: rtl/dbg_slave_sysclk_cmdq.sv
// System-clock half of the debug slave: synchronises update strobes from the
// TCK domain, queues DR/IR commands and decodes per-instruction action pulses.
module dbg_slave_sysclk_cmdq
    import dbg_slave_pkg::*;
#(
    parameter int IR_WIDTH    = DEF_IR_WIDTH,
    parameter int DR_WIDTH    = DEF_DR_WIDTH,
    parameter int ACTION_BIT  = DEF_ACTION_BIT,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int AUTO_POP    = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vs_uir,
    input  logic                              vs_udr,
    input  logic [IR_WIDTH-1:0]               ir_in,
    input  logic [DR_WIDTH-1:0]               sr,
    input  logic                              cmd_ready,
    input  logic                              ovf_clr,
    output logic                              cmd_valid,
    output logic [IR_WIDTH-1:0]               cmd_ir,
    output logic [DR_WIDTH-1:0]               cmd_data,
    output logic [IR_WIDTH-1:0]               ir_latched,
    output logic                              ir_update,
    output logic [(2**IR_WIDTH)-1:0]          take_action,
    output logic [(2**IR_WIDTH)-1:0]          take_no_action,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                              overflow
);

    localparam int   NUM_CODES   = 2**IR_WIDTH;
    localparam int   PTR_W       = clog2(FIFO_DEPTH);
    localparam int   LVL_W       = clog2(FIFO_DEPTH+1);
    localparam logic AUTO_POP_EN = (AUTO_POP != 0);

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [DR_WIDTH-1:0] data;
    } cmd_t;

    cmd_t                 mem [FIFO_DEPTH];
    cmd_t                 head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 uir_rise;
    logic                 udr_rise;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic                 drop;
    logic [NUM_CODES-1:0] head_onehot;

    dbg_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_uir (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    dbg_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_udr (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    assign head      = mem[rd_ptr];
    assign cmd_ir    = head.ir;
    assign cmd_data  = head.data;
    assign cmd_valid = (fifo_level != '0);

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    always_comb begin
        full        = (fifo_level == LVL_W'(FIFO_DEPTH));
        push        = udr_rise;
        pop         = cmd_valid & (cmd_ready | AUTO_POP_EN);
        accept      = push & (~full | pop);
        drop        = push & full & ~pop;
        head_onehot = NUM_CODES'(1) << head.ir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= '{ir: ir_in, data: sr};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_latched <= '0;
            ir_update  <= 1'b0;
        end else begin
            ir_update <= uir_rise;
            if (uir_rise) begin
                ir_latched <= ir_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (head.data[ACTION_BIT]) begin
                    take_action <= head_onehot;
                end else begin
                    take_no_action <= head_onehot;
                end
            end
        end
    end

endmodule
